// File: rtl/divu_hilo_unit.sv
// Multi-cycle restoring unsigned divider feeding the HI/LO register pair.
// One quotient bit per DIV_CODE edge; OPEN_CODE in DONE commits rem->HI, quo->LO.
module divu_hilo_unit #(
  parameter int          WIDTH     = 32,
  parameter logic [5:0]  DIV_CODE  = 6'b011011,
  parameter logic [5:0]  OPEN_CODE = 6'b111111
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [5:0]       i_ctrl,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_ready,
  output logic             o_hilo_we,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_rem, r_quo, r_dsr, r_hi, r_lo;
  logic [CW-1:0]    r_cnt;
  logic             r_hilo_we;

  logic             w_div, w_open;
  logic [WIDTH-1:0] w_rem_src, w_quo_src, w_dsr_src, w_t;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt;

  assign w_div  = (i_ctrl == DIV_CODE);
  assign w_open = (i_ctrl == OPEN_CODE);

  // The start edge iterates straight from {0, dividend} so no load cycle is lost.
  assign w_rem_src = (r_state == IDLE) ? '0 : r_rem;
  assign w_quo_src = (r_state == IDLE) ? i_dividend : r_quo;
  assign w_dsr_src = (r_state == IDLE) ? i_divisor : r_dsr;

  // rem < 2^(k+1) after iteration k, so dropping rem[MSB] never loses a set bit.
  assign w_t       = {w_rem_src[WIDTH-2:0], w_quo_src[WIDTH-1]};
  assign w_diff    = {1'b0, w_t} - {1'b0, w_dsr_src};
  assign w_rem_nxt = w_diff[WIDTH] ? w_t : w_diff[WIDTH-1:0];
  assign w_quo_nxt = {w_quo_src[WIDTH-2:0], ~w_diff[WIDTH]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_div) w_state_nxt = RUN;
      RUN: begin
        if (!w_div)                             w_state_nxt = IDLE;
        else if (r_cnt == CW'(WIDTH - 1))       w_state_nxt = DONE;
      end
      DONE: if (!w_div) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_dsr     <= '0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_hilo_we <= 1'b0;
    end else begin
      r_hilo_we <= 1'b0;
      unique case (r_state)
        IDLE: if (w_div) begin
          r_dsr <= i_divisor;
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= CW'(1);
        end
        RUN: if (w_div) begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        DONE: if (w_open) begin
          r_hi      <= r_rem;
          r_lo      <= r_quo;
          r_hilo_we <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy    = (r_state == RUN);
  assign o_ready   = (r_state == DONE);
  assign o_hilo_we = r_hilo_we;
  assign o_hi      = r_hi;
  assign o_lo      = r_lo;

endmodule

// File: tb/tb_divu_hilo_unit.sv
// Randomized bench for divu_hilo_unit against an arithmetic (/ and %) reference.
module tb_divu_hilo_unit;
  localparam int         W    = 32;
  localparam logic [5:0] DIV  = 6'b011011;
  localparam logic [5:0] OPEN = 6'b111111;
  localparam logic [5:0] NOP  = 6'b100000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [5:0]   ctrl;
  logic [W-1:0] dvd, dsr;
  logic         busy, ready, hilo_we;
  logic [W-1:0] hi, lo;

  logic [W-1:0] exp_hi = '0, exp_lo = '0;
  int n_chk  = 0;
  int n_pass = 0;

  divu_hilo_unit #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ctrl(ctrl), .i_dividend(dvd), .i_divisor(dsr),
    .o_busy(busy), .o_ready(ready), .o_hilo_we(hilo_we), .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] z(input logic x);
    return {{(W-1){1'b0}}, x};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Divide by zero yields all-ones quotient and the dividend as remainder.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    if (b == '0) begin q = '1; r = a; end
    else begin q = a / b; r = a % b; end
  endfunction

  // Inputs change at negedge; outputs are sampled at the following negedge.
  task automatic step(input logic [5:0] c);
    ctrl = c;
    @(negedge clk);
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    dvd = a;
    dsr = b;
    for (int i = 0; i < W; i++) begin
      step(DIV);
      dvd = $urandom;
      dsr = $urandom;
      if (i == 0) begin
        chk("we_run", z(hilo_we), '0);
        chk("hi_keep", hi, exp_hi);
        chk("lo_keep", lo, exp_lo);
      end
      if (i < W-1) chk("busy_run", z(busy), 32'd1);
      if (i == W-2) chk("ready_early", z(ready), '0);
    end
    chk("ready_done", z(ready), 32'd1);
    chk("busy_done", z(busy), '0);
    for (int h = 0; h < hold; h++) begin
      step(DIV);
      chk("ready_hold", z(ready), 32'd1);
    end
  endtask

  task automatic commit(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    ref_div(a, b, q, r);
    step(OPEN);
    exp_hi = r;
    exp_lo = q;
    chk("we_commit", z(hilo_we), 32'd1);
    chk("hi_commit", hi, exp_hi);
    chk("lo_commit", lo, exp_lo);
    chk("idle_after", z(busy | ready), '0);
  endtask

  task automatic full(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    run_div(a, b, hold);
    commit(a, b);
    step(NOP);
    chk("we_pulse", z(hilo_we), '0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    rst_n = 1'b0; ctrl = '0; dvd = '0; dsr = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", z(busy), '0);
    chk("rst_ready", z(ready), '0);
    chk("rst_we", z(hilo_we), '0);
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    rst_n = 1'b1;

    step(OPEN);
    chk("open_idle_we", z(hilo_we), '0);

    full(32'd100, 32'd7, 0);
    full(32'hFFFFFFFF, 32'd1, 1);
    full(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    full(32'h12345678, 32'd0, 2);

    // Abort in RUN: no write, HI/LO untouched, later OPEN ignored.
    dvd = 32'd1000; dsr = 32'd3;
    repeat (10) step(DIV);
    step(NOP);
    chk("abort_busy", z(busy), '0);
    chk("abort_ready", z(ready), '0);
    chk("abort_we", z(hilo_we), '0);
    chk("abort_hi", hi, exp_hi);
    chk("abort_lo", lo, exp_lo);
    step(OPEN);
    chk("abort_open_we", z(hilo_we), '0);
    chk("abort_open_lo", lo, exp_lo);

    // Abort from DONE with a foreign code.
    run_div(32'd77, 32'd5, 0);
    step(NOP);
    chk("done_drop_ready", z(ready), '0);
    step(OPEN);
    chk("done_drop_we", z(hilo_we), '0);
    chk("done_drop_hi", hi, exp_hi);

    // Back-to-back: new DIV on the edge right after the commit.
    run_div(32'd50, 32'd5, 0);
    commit(32'd50, 32'd5);
    run_div(32'd9, 32'd4, 0);
    commit(32'd9, 32'd4);
    step(NOP);
    chk("b2b_lo", lo, 32'd2);
    chk("b2b_hi", hi, 32'd1);

    // Asynchronous reset in the middle of a division.
    dvd = 32'd123456; dsr = 32'd789;
    repeat (15) step(DIV);
    #2 rst_n = 1'b0;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    chk("arst_busy", z(busy), '0);
    chk("arst_hi", hi, '0);
    chk("arst_lo", lo, '0);
    chk("arst_we", z(hilo_we), '0);
    @(negedge clk);
    rst_n = 1'b1;
    step(OPEN);
    chk("arst_open_we", z(hilo_we), '0);
    chk("arst_open_lo", lo, '0);
    full(32'd1000, 32'd33, 0);

    for (int k = 0; k < 24; k++) begin
      a = $urandom;
      case ($urandom_range(3))
        0:       b = '0;
        1:       b = $urandom_range(16, 1);
        2:       b = $urandom;
        default: b = a >> $urandom_range(31, 1);
      endcase
      full(a, b, $urandom_range(2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/divu_hilo_unit.md
Name: divu_hilo_unit

Overview:
- Multi-cycle unsigned divider plus the HI/LO register pair. It is the consumer of the ALU control code stream.
- While the control code equals the DIVU funct, the block iterates a restoring shift-subtract division, one quotient bit per clock.
- When the control stage later emits the "open HiLo" code, the block commits remainder to HI and quotient to LO.
- Sits beside the ALU in EX. Its HI/LO outputs feed MFHI/MFLO forwarding.

Parameters:
- WIDTH, 32, operand/quotient/remainder width; iteration count = WIDTH.
- DIV_CODE, 6'b011011, control code meaning "divide in progress".
- OPEN_CODE, 6'b111111, control code meaning "commit result to HI/LO".

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ctrl  input  6  ALU control code from the control stage.
- dividend  input  WIDTH  rs operand; sampled on the start edge only.
- divisor  input  WIDTH  rt operand; sampled on the start edge only.
- busy  output  1  high in RUN.
- ready  output  1  high in DONE (result computed, not yet committed).
- hilo_we  output  1  one-cycle registered pulse on the edge HI/LO are written.
- hi  output  WIDTH  HI register (remainder).
- lo  output  WIDTH  LO register (quotient).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, ready=0, hilo_we=0, hi=0, lo=0; internal rem/quo/dsr/count=0. Reset mid-RUN or mid-DONE discards the operation; HI/LO are cleared.
- States:
  - IDLE: on edge with ctrl==DIV_CODE, load dsr=divisor and perform iteration 0 from {0,dividend}; count=1; go to RUN.
  - RUN: each edge with ctrl==DIV_CODE performs one iteration and increments count. The edge completing iteration WIDTH-1 (count==WIDTH-1 before the edge) goes to DONE. Total: start edge plus 31 edges, so the result is available after 32 consecutive DIV edges.
  - RUN abort: any edge with ctrl!=DIV_CODE in RUN (including OPEN_CODE) returns to IDLE. No HI/LO write.
  - DONE, ctrl==DIV_CODE: hold the result.
  - DONE, ctrl==OPEN_CODE: hi<=rem, lo<=quo, hilo_we=1 for that cycle, go to IDLE.
  - DONE, any other code: discard the result, go to IDLE.
- Iteration (restoring): t={rem[WIDTH-2:0],quo[WIDTH-1]}. Compare using a WIDTH+1-bit subtract t-dsr (no overflow loss).
  - If t>=dsr: rem=t-dsr, quo={quo[WIDTH-2:0],1}.
  - Else: rem=t, quo={quo[WIDTH-2:0],0}.
- Divide by zero: no special case. Natural result is quo=all ones, rem=dividend.
- OPEN_CODE seen in IDLE: no effect, no write, hilo_we stays 0.
- Back-to-back: DIV_CODE on the edge immediately after a commit (state IDLE) starts a new division. HI/LO keep their committed values until the next commit.
- Output timing: hi/lo/hilo_we are registered and change only on the commit edge. busy and ready decode state (Moore). hilo_we is never high outside the cycle after a commit edge.
- Operands are don't-care after the start edge; changes during RUN do not affect the result.

Test Plan:
- Reset, then ctrl=DIV_CODE with dividend=100, divisor=7 for 32 edges, then OPEN_CODE for 1 edge -> ready high after edge 32; on commit edge lo=14, hi=2, hilo_we=1 for one cycle then 0; busy=0.
- dividend=32'hFFFFFFFF, divisor=1, same sequence -> lo=32'hFFFFFFFF, hi=0. Repeat with divisor=32'hFFFFFFFF -> lo=1, hi=0.
- divisor=0, dividend=32'h12345678 -> lo=32'hFFFFFFFF, hi=32'h12345678 after commit.
- DIV_CODE for 10 edges, then ctrl=6'b100000 -> state IDLE, busy=0, ready never asserted, hi/lo unchanged from prior values, hilo_we stays 0. An OPEN_CODE afterwards also produces no write.
- Complete 50/5 (lo=10, hi=0), then DIV_CODE on the very next edge with 9/4 -> hi/lo stay 0/10 until the second commit, then lo=2, hi=1.
- rst_n pulsed low at edge 15 of a division -> all outputs 0 immediately (async). After release, OPEN_CODE causes no write; a new DIV sequence runs normally.
